// File: rtl/axis_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module   : axis_width_downsizer
// Purpose  : AXI-Stream width downsizer; splits each DW_IN-bit word into
//            RATIO = DW_IN/DW_OUT narrow beats, tlast on the final beat.
// Revision : 1.0 - initial release
// ============================================================================
module axis_width_downsizer #(
  parameter int DW_IN     = 24,
  parameter int DW_OUT    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DW_IN-1:0]  s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DW_OUT-1:0] m_axis_tdata,
  output logic              m_axis_tlast
);

  localparam int RATIO = DW_IN / DW_OUT;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(RATIO - 1);

  logic [DW_IN-1:0] word_q, word_d;
  logic             last_q, last_d;
  logic             full_q, full_d;
  logic [IDX_W-1:0] idx_q,  idx_d;

  logic [DW_OUT-1:0] w_slice [RATIO];
  logic              w_idx_last;
  logic              w_m_fire;
  logic              w_s_fire;

  // Slice 0 is whichever end of the word leaves first.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign w_slice[gi] = word_q[DW_IN-1-gi*DW_OUT -: DW_OUT];
    end else begin : g_lsb
      assign w_slice[gi] = word_q[gi*DW_OUT +: DW_OUT];
    end
  end

  assign w_idx_last = (idx_q == C_IDX_LAST);

  // Ready never depends on s_axis_tvalid, so no combinational loop upstream.
  assign s_axis_tready = ~full_q | (m_axis_tready & w_idx_last);
  assign m_axis_tvalid = full_q;
  assign m_axis_tlast  = full_q & last_q & w_idx_last;

  assign w_m_fire = full_q & m_axis_tready;
  assign w_s_fire = s_axis_tvalid & s_axis_tready;

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IDX_W'(i)) begin
        m_axis_tdata = w_slice[i];
      end
    end
  end

  always_comb begin
    word_d = word_q;
    last_d = last_q;
    full_d = full_q;
    idx_d  = idx_q;
    if (w_m_fire) begin
      if (w_idx_last) begin
        idx_d  = '0;
        full_d = 1'b0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
    end
    // A load in the same cycle as the final beat keeps the output busy.
    if (w_s_fire) begin
      word_d = s_axis_tdata;
      last_d = s_axis_tlast;
      full_d = 1'b1;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      last_q <= last_d;
      full_q <= full_d;
      idx_q  <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_width_downsizer
// Purpose  : Directed and random self-checking bench for axis_width_downsizer
//            (MSB-first and LSB-first instances on shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_width_downsizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b0;

  logic        s_tready_m, m_tvalid_m, m_tlast_m;
  logic [7:0]  m_tdata_m;
  logic        s_tready_l, m_tvalid_l, m_tlast_l;
  logic [7:0]  m_tdata_l;

  int checks = 0;
  int errors = 0;

  int  rnd_words = 0;
  int  rnd_beats = 0;
  bit  rnd_on = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q_m[$];
  beat_t q_l[$];

  always #5 clk = ~clk;

  axis_width_downsizer #(.DW_IN(24), .DW_OUT(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_m),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid_m), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata_m), .m_axis_tlast(m_tlast_m)
  );

  axis_width_downsizer #(.DW_IN(24), .DW_OUT(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_l),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid_l), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata_l), .m_axis_tlast(m_tlast_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each accepted word becomes three pending bytes; the output is valid
  // exactly while bytes are pending, and a new word fits only when at most the
  // final byte of the current word remains and it is leaving this cycle.
  task automatic model_check(input string tag, ref beat_t q[$], input logic v,
                             input logic [7:0] d, input logic l, input logic r);
    logic exp_rdy;
    exp_rdy = (q.size() == 0) || (m_tready && q.size() == 1);
    chk({tag, "_m_tvalid"}, {31'd0, v}, {31'd0, q.size() != 0});
    chk({tag, "_s_tready"}, {31'd0, r}, {31'd0, exp_rdy});
    if (q.size() != 0) begin
      chk({tag, "_m_tdata"}, {24'd0, d}, {24'd0, q[0].data});
      chk({tag, "_m_tlast"}, {31'd0, l}, {31'd0, q[0].last});
    end
  endtask

  always @(negedge clk) begin
    logic rdy_exp;
    if (reset) begin
      q_m.delete();
      q_l.delete();
    end else begin
      rdy_exp = (q_m.size() == 0) || (m_tready && q_m.size() == 1);
      model_check("msb", q_m, m_tvalid_m, m_tdata_m, m_tlast_m, s_tready_m);
      model_check("lsb", q_l, m_tvalid_l, m_tdata_l, m_tlast_l, s_tready_l);
      if (rnd_on && m_tvalid_m && m_tready) rnd_beats++;
      if (q_m.size() != 0 && m_tready) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (s_tvalid && rdy_exp) begin
        for (int k = 0; k < 3; k++) begin
          q_m.push_back('{data: s_tdata[8*(2-k) +: 8], last: s_tlast && (k == 2)});
          q_l.push_back('{data: s_tdata[8*k +: 8],     last: s_tlast && (k == 2)});
        end
        if (rnd_on) rnd_words++;
      end
    end
  end

  task automatic cycle(input logic sv, input logic [23:0] sd, input logic sl, input logic mr);
    @(posedge clk);
    #1;
    s_tvalid = sv;
    s_tdata  = sd;
    s_tlast  = sl;
    m_tready = mr;
    @(negedge clk);
  endtask

  task automatic beat(input string name, input logic [7:0] dm, input logic lm,
                      input logic [7:0] dl, input logic ll);
    chk({name, "_v"},   {31'd0, m_tvalid_m}, 32'd1);
    chk({name, "_d"},   {24'd0, m_tdata_m},  {24'd0, dm});
    chk({name, "_l"},   {31'd0, m_tlast_m},  {31'd0, lm});
    chk({name, "_vL"},  {31'd0, m_tvalid_l}, 32'd1);
    chk({name, "_dL"},  {24'd0, m_tdata_l},  {24'd0, dl});
    chk({name, "_lL"},  {31'd0, m_tlast_l},  {31'd0, ll});
  endtask

  initial begin
    logic acc;
    int   sent;
    int   cyc;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", {31'd0, m_tvalid_m}, 32'd0);
    chk("rst_m_tlast",  {31'd0, m_tlast_m},  32'd0);
    chk("rst_m_tdata",  {24'd0, m_tdata_m},  32'd0);
    chk("rst_s_tready", {31'd0, s_tready_m}, 32'd1);

    // Single word, both slice orders.
    cycle(1'b1, 24'hA1B2C3, 1'b1, 1'b1);
    chk("t1_accept", {31'd0, s_tready_m}, 32'd1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t1_b0", 8'hA1, 1'b0, 8'hC3, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t1_b1", 8'hB2, 1'b0, 8'hB2, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t1_b2", 8'hC3, 1'b1, 8'hA1, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    chk("t1_idle_v", {31'd0, m_tvalid_m}, 32'd0);

    // Back-to-back words, no bubble between them.
    cycle(1'b1, 24'h010203, 1'b0, 1'b1);
    cycle(1'b1, 24'h040506, 1'b1, 1'b1);
    beat("t3_01", 8'h01, 1'b0, 8'h03, 1'b0);
    chk("t3_rdy01", {31'd0, s_tready_m}, 32'd0);
    cycle(1'b1, 24'h040506, 1'b1, 1'b1);
    chk("t3_d02", {24'd0, m_tdata_m}, 32'h02);
    chk("t3_rdy02", {31'd0, s_tready_m}, 32'd0);
    cycle(1'b1, 24'h040506, 1'b1, 1'b1);
    chk("t3_d03", {24'd0, m_tdata_m}, 32'h03);
    chk("t3_rdy03", {31'd0, s_tready_m}, 32'd1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t3_04", 8'h04, 1'b0, 8'h06, 1'b0);
    chk("t3_rdy04", {31'd0, s_tready_m}, 32'd0);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    chk("t3_d05", {24'd0, m_tdata_m}, 32'h05);
    chk("t3_rdy05", {31'd0, s_tready_m}, 32'd0);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t3_06", 8'h06, 1'b1, 8'h04, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);

    // Back-pressure while B2 is presented.
    cycle(1'b1, 24'hA1B2C3, 1'b1, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    chk("t4_a1", {24'd0, m_tdata_m}, 32'hA1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 24'hDEADBE, 1'b0, 1'b0);
      chk("t4_hold_v", {31'd0, m_tvalid_m}, 32'd1);
      chk("t4_hold_d", {24'd0, m_tdata_m},  32'hB2);
      chk("t4_hold_rdy", {31'd0, s_tready_m}, 32'd0);
    end
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    chk("t4_b2", {24'd0, m_tdata_m}, 32'hB2);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t4_c3", 8'hC3, 1'b1, 8'hA1, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);

    // Reset after the first beat leaves.
    cycle(1'b1, 24'hA1B2C3, 1'b1, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    chk("t5_a1", {24'd0, m_tdata_m}, 32'hA1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_v",   {31'd0, m_tvalid_m}, 32'd0);
    chk("t5_rst_rdy", {31'd0, s_tready_m}, 32'd1);
    cycle(1'b1, 24'h112233, 1'b1, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t5_11", 8'h11, 1'b0, 8'h33, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t5_22", 8'h22, 1'b0, 8'h22, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);
    beat("t5_33", 8'h33, 1'b1, 8'h11, 1'b1);
    cycle(1'b0, 24'h0, 1'b0, 1'b1);

    // Random valid/ready; valid is held until its handshake.
    rnd_on = 1'b1;
    sent = 0;
    acc = 1'b0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (acc) s_tvalid = 1'b0;
      if (!s_tvalid && $urandom_range(0, 3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata  = 24'($urandom);
        s_tlast  = ($urandom_range(0, 3) == 0);
      end
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = s_tvalid && s_tready_m;
      if (acc) sent++;
      cyc++;
    end
    chk("rnd_words_sent", sent, 32'd1000);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rnd_drained_v", {31'd0, m_tvalid_m}, 32'd0);
    chk("rnd_word_count", rnd_words, sent);
    chk("rnd_beat_count", rnd_beats, 3 * rnd_words);
    rnd_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
